// File: rtl/throw_turn_ctl.sv
// throw_turn_ctl: turn and throw controller for the two-player throwing game.
// Synchronizes and debounces the throw button. Measures the hold time to set
// the launch power. Launches the projectile and alternates turns between the
// left and right player.
// Optional build macro THROW_TIMEOUT_EN adds a flight counter that ends a
// throw after THROW_TIMEOUT cycles in flight without projectile_done.
module throw_turn_ctl #(
  parameter int DEBOUNCE_CYCLES = 600_000,
  parameter int POWER_STEP      = 1_200_000,
  parameter int THROW_TIMEOUT   = 300_000_000
) (
  input  logic       clk60MHz,
  input  logic       rst,
  input  logic       game_en,
  input  logic       btn_throw,
  input  logic       projectile_done,
  output logic       turn,
  output logic       throw_flag,
  output logic       left,
  output logic       throw_start,
  output logic [7:0] throw_power
);

  localparam int DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int STEP_W   = (POWER_STEP > 1) ? $clog2(POWER_STEP) : 1;
  localparam int FLIGHT_W = (THROW_TIMEOUT > 1) ? $clog2(THROW_TIMEOUT) : 1;

  localparam logic [DB_W-1:0]   DB_ZERO   = {DB_W{1'b0}};
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_ZERO = {STEP_W{1'b0}};
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(POWER_STEP - 1);

  // Parameter sanity: a debouncer needs at least two cycles, the other
  // periods at least one.
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("throw_turn_ctl: DEBOUNCE_CYCLES must be at least 2");
  end
  if (POWER_STEP < 1) begin : g_bad_power_step
    $error("throw_turn_ctl: POWER_STEP must be at least 1");
  end
  if (THROW_TIMEOUT < 1) begin : g_bad_timeout
    $error("throw_turn_ctl: THROW_TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_AIM    = 3'd1,
    ST_CHARGE = 3'd2,
    ST_FLIGHT = 3'd3,
    ST_SWAP   = 3'd4
  } state_t;

  // Saturating +1 for the 8-bit power value.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = 8'hFF;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

  state_t            state_r;
  state_t            state_s;
  logic              sync1_r;
  logic              sync2_r;
  logic              db_level_r;
  logic              db_prev_r;
  logic [DB_W-1:0]   db_cnt_r;
  logic              press_s;
  logic              rel_s;
  logic [STEP_W-1:0] step_cnt_r;
  logic [STEP_W-1:0] step_cnt_s;
  logic [7:0]        power_s;
  logic              left_s;
  logic              start_s;
  logic              turn_s;
  logic              flag_s;
  logic              timeout_s;

`ifdef THROW_TIMEOUT_EN
  localparam logic [FLIGHT_W-1:0] FLIGHT_ZERO = {FLIGHT_W{1'b0}};
  localparam logic [FLIGHT_W-1:0] FLIGHT_ONE  = FLIGHT_W'(1);
  localparam logic [FLIGHT_W-1:0] FLIGHT_LAST = FLIGHT_W'(THROW_TIMEOUT - 1);

  logic [FLIGHT_W-1:0] flight_cnt_r;
  logic [FLIGHT_W-1:0] flight_cnt_s;

  // The flight has run its full budget on the last counted cycle.
  assign timeout_s = (state_r == ST_FLIGHT) && (flight_cnt_r == FLIGHT_LAST);
`else
  assign timeout_s = 1'b0;
`endif

  // Two-flop synchronizer followed by the debounce filter on the raw button.
  always_ff @(posedge clk60MHz) begin
    if (!rst) begin
      sync1_r    <= 1'b0;
      sync2_r    <= 1'b0;
      db_level_r <= 1'b0;
      db_prev_r  <= 1'b0;
      db_cnt_r   <= DB_ZERO;
    end else begin
      sync1_r   <= btn_throw;
      sync2_r   <= sync1_r;
      db_prev_r <= db_level_r;
      if (sync2_r == db_level_r) begin
        db_cnt_r <= DB_ZERO;
      end else if (db_cnt_r == DB_LAST) begin
        db_level_r <= sync2_r;
        db_cnt_r   <= DB_ZERO;
      end else begin
        db_cnt_r <= db_cnt_r + DB_ONE;
      end
    end
  end

  // One-cycle strobes on the debounced level edges; combinational so the
  // FSM reacts on the edge right after the level changes.
  assign press_s = db_level_r & ~db_prev_r;
  assign rel_s   = ~db_level_r & db_prev_r;

  // Next-state, counter and output decode for the turn FSM.
  always_comb begin
    state_s    = state_r;
    power_s    = throw_power;
    step_cnt_s = STEP_ZERO;
    left_s     = left;
    start_s    = 1'b0;
`ifdef THROW_TIMEOUT_EN
    flight_cnt_s = FLIGHT_ZERO;
`endif
    if (!game_en) begin
      state_s = ST_IDLE;
      power_s = 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_AIM;
        end
        ST_AIM: begin
          if (press_s) begin
            state_s = ST_CHARGE;
            power_s = 8'd0;
          end else begin
            state_s = ST_AIM;
          end
        end
        ST_CHARGE: begin
          // The power step still lands when release arrives on the wrap cycle.
          if (step_cnt_r == STEP_LAST) begin
            step_cnt_s = STEP_ZERO;
            power_s    = sat_inc(throw_power);
          end else begin
            step_cnt_s = step_cnt_r + STEP_ONE;
            power_s    = throw_power;
          end
          if (rel_s) begin
            state_s    = ST_FLIGHT;
            start_s    = 1'b1;
            step_cnt_s = STEP_ZERO;
          end else begin
            state_s = ST_CHARGE;
          end
        end
        ST_FLIGHT: begin
          if (projectile_done || timeout_s) begin
            state_s = ST_SWAP;
          end else begin
            state_s = ST_FLIGHT;
`ifdef THROW_TIMEOUT_EN
            flight_cnt_s = flight_cnt_r + FLIGHT_ONE;
`endif
          end
        end
        ST_SWAP: begin
          left_s  = ~left;
          state_s = ST_AIM;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
    turn_s = (state_s == ST_AIM) || (state_s == ST_CHARGE);
    flag_s = (state_s == ST_FLIGHT);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk60MHz) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      step_cnt_r  <= STEP_ZERO;
      turn        <= 1'b0;
      throw_flag  <= 1'b0;
      left        <= 1'b1;
      throw_start <= 1'b0;
      throw_power <= 8'd0;
`ifdef THROW_TIMEOUT_EN
      flight_cnt_r <= FLIGHT_ZERO;
`endif
    end else begin
      state_r     <= state_s;
      step_cnt_r  <= step_cnt_s;
      turn        <= turn_s;
      throw_flag  <= flag_s;
      left        <= left_s;
      throw_start <= start_s;
      throw_power <= power_s;
`ifdef THROW_TIMEOUT_EN
      flight_cnt_r <= flight_cnt_s;
`endif
    end
  end

endmodule
